// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two-flop synchroniser and stability-count debouncer with press/release strobes
module key_debounce #(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  // Final count value: the sample that completes a run of STABLE_CYCLES agreeing samples.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic             r_sync0;
  logic             r_sync1;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_key_level;
  logic             r_press;
  logic             r_release;

  // Bring the asynchronous button level into the clk domain; only r_sync1 is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
    end else begin
      r_sync0 <= key_in;
      r_sync1 <= r_sync0;
    end
  end

  // Debounce FSM: a level change is accepted only after STABLE_CYCLES consecutive
  // agreeing samples; any disagreeing sample drops back to the prior stable state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_key_level <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_sync1) begin
            r_state <= PRESS_CHK;
            r_cnt   <= ONE;
          end else begin
            r_cnt <= '0;
          end
        end
        PRESS_CHK: begin
          if (!r_sync1) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == LAST) begin
            r_state     <= HELD;
            r_press     <= 1'b1;
            r_key_level <= 1'b1;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + ONE;
          end
        end
        HELD: begin
          if (!r_sync1) begin
            r_state <= RELEASE_CHK;
            r_cnt   <= ONE;
          end
        end
        RELEASE_CHK: begin
          if (r_sync1) begin
            r_state <= HELD;
            r_cnt   <= '0;
          end else if (r_cnt == LAST) begin
            r_state     <= IDLE;
            r_release   <= 1'b1;
            r_key_level <= 1'b0;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + ONE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cnt       <= '0;
          r_key_level <= 1'b0;
        end
      endcase
    end
  end

  assign key_level     = r_key_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - randomized and directed self-checking bench for key_debounce
module tb_key_debounce;

  localparam int S = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_in = 1'b0;
  logic key_level;
  logic press_pulse;
  logic release_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: accepted level plus length of the current run of synchronised
  // samples that disagree with it; S disagreeing samples in a row flip the level.
  bit m_s0, m_s1, m_level, m_press, m_rel;
  int m_run;

  key_debounce #(.STABLE_CYCLES(S), .CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .key_in(key_in),
    .key_level(key_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_s0 = 1'b0; m_s1 = 1'b0; m_level = 1'b0;
    m_press = 1'b0; m_rel = 1'b0; m_run = 0;
  endtask

  // Drive key_in at the falling edge, advance the model at the rising edge, return 1 time unit later.
  task automatic step(input logic k);
    bit v;
    @(negedge clk);
    key_in = k;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      v = m_s1;
      m_s1 = m_s0;
      m_s0 = k;
      m_press = 1'b0;
      m_rel = 1'b0;
      if (v != m_level) begin
        m_run++;
        if (m_run == S) begin
          m_level = v;
          m_run = 0;
          if (v) m_press = 1'b1; else m_rel = 1'b1;
        end
      end else begin
        m_run = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({key_level, press_pulse, release_pulse} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_state: got %b exp 000", {key_level, press_pulse, release_pulse});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      n_checks++;
      if ({key_level, press_pulse, release_pulse} !== 3'b000) begin
        n_fail++;
        $display("FAIL idle_quiet cycle %0d: got %b exp 000", i, {key_level, press_pulse, release_pulse});
      end
    end
  endtask

  task automatic test_press_release();
    int press_at, rel_at, np, nr;
    press_at = -1; np = 0; nr = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1);
      if (press_pulse) begin press_at = i; np++; end
      if (release_pulse) nr++;
      n_checks++;
      if ({key_level, press_pulse, release_pulse} !== {m_level, m_press, m_rel}) begin
        n_fail++;
        $display("FAIL press_seq edge %0d: got %b exp %b", i, {key_level, press_pulse, release_pulse}, {m_level, m_press, m_rel});
      end
    end
    n_checks++;
    if (press_at != S + 2 || np != 1 || nr != 0 || key_level !== 1'b1) begin
      n_fail++;
      $display("FAIL press_latency: got edge %0d presses %0d releases %0d level %b exp edge %0d 1 0 1", press_at, np, nr, key_level, S + 2);
    end
    rel_at = -1; np = 0; nr = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b0);
      if (release_pulse) begin rel_at = i; nr++; end
      if (press_pulse) np++;
      n_checks++;
      if ({key_level, press_pulse, release_pulse} !== {m_level, m_press, m_rel}) begin
        n_fail++;
        $display("FAIL release_seq edge %0d: got %b exp %b", i, {key_level, press_pulse, release_pulse}, {m_level, m_press, m_rel});
      end
    end
    n_checks++;
    if (rel_at != S + 2 || nr != 1 || np != 0 || key_level !== 1'b0) begin
      n_fail++;
      $display("FAIL release_latency: got edge %0d releases %0d presses %0d level %b exp edge %0d 1 0 0", rel_at, nr, np, key_level, S + 2);
    end
  endtask

  task automatic test_release_glitch();
    logic pat [0:14];
    int rel_at, nr;
    for (int i = 0; i < 12; i++) step(1'b1);
    for (int i = 0; i < 15; i++) pat[i] = (i == 2) ? 1'b1 : 1'b0;
    rel_at = -1; nr = 0;
    for (int i = 0; i < 15; i++) begin
      step(pat[i]);
      if (release_pulse) begin rel_at = i + 1; nr++; end
      n_checks++;
      if ({key_level, press_pulse, release_pulse} !== {m_level, m_press, m_rel}) begin
        n_fail++;
        $display("FAIL glitch_seq edge %0d: got %b exp %b", i + 1, {key_level, press_pulse, release_pulse}, {m_level, m_press, m_rel});
      end
    end
    n_checks++;
    if (nr != 1 || rel_at <= S + 2) begin
      n_fail++;
      $display("FAIL glitch_restart: got %0d releases at edge %0d exp 1 release after edge %0d", nr, rel_at, S + 2);
    end
  endtask

  task automatic test_bounce();
    logic pat [0:11];
    int np;
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    np = 0;
    for (int i = 0; i < 12; i++) begin
      step(pat[i]);
      if (press_pulse) np++;
      n_checks++;
      if ({key_level, press_pulse, release_pulse} !== {m_level, m_press, m_rel}) begin
        n_fail++;
        $display("FAIL bounce_seq cycle %0d: got %b exp %b", i, {key_level, press_pulse, release_pulse}, {m_level, m_press, m_rel});
      end
    end
    n_checks++;
    if (np != 0 || key_level !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_reject: got %0d presses level %b exp 0 presses level 0", np, key_level);
    end
    np = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1);
      if (press_pulse) np++;
    end
    n_checks++;
    if (np != 1 || key_level !== 1'b1) begin
      n_fail++;
      $display("FAIL clean_after_bounce: got %0d presses level %b exp 1 presses level 1", np, key_level);
    end
    for (int i = 0; i < 10; i++) step(1'b0);
  endtask

  task automatic test_async_reset();
    int press_at, nr;
    for (int i = 0; i < 4; i++) step(1'b1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({key_level, press_pulse, release_pulse} !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset_chk: got %b exp 000", {key_level, press_pulse, release_pulse});
    end
    step(1'b1);
    step(1'b1);
    rst = 1'b0;
    press_at = -1; nr = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1);
      if (press_pulse && press_at < 0) press_at = i;
      if (release_pulse) nr++;
    end
    n_checks++;
    if (press_at != S + 2 || nr != 0) begin
      n_fail++;
      $display("FAIL reset_redetect: got press edge %0d releases %0d exp edge %0d releases 0", press_at, nr, S + 2);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({key_level, press_pulse, release_pulse} !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset_held: got %b exp 000", {key_level, press_pulse, release_pulse});
    end
    step(1'b0);
    rst = 1'b0;
    nr = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      if (release_pulse) nr++;
    end
    n_checks++;
    if (nr != 0 || key_level !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_release: got %0d releases level %b exp 0 level 0", nr, key_level);
    end
  endtask

  task automatic test_counter();
    logic [3:0] cnt4;
    int np, nr, np_low;
    cnt4 = 4'h0; np = 0; nr = 0; np_low = 0;
    for (int p = 0; p < 17; p++) begin
      for (int i = 0; i < 8; i++) begin
        step(1'b1);
        if (press_pulse) begin cnt4 = cnt4 + 4'h1; np++; end
      end
      for (int i = 0; i < 8; i++) begin
        step(1'b0);
        if (press_pulse) np_low++;
        if (release_pulse) nr++;
      end
    end
    n_checks++;
    if (np != 17 || nr != 17 || np_low != 0) begin
      n_fail++;
      $display("FAIL counter_pulses: got press %0d release %0d press_on_release %0d exp 17 17 0", np, nr, np_low);
    end
    n_checks++;
    if (cnt4 !== 4'h1) begin
      n_fail++;
      $display("FAIL counter_wrap: got %h exp 1", cnt4);
    end
  endtask

  task automatic test_random();
    logic lvl;
    int run;
    logic prev_pulse;
    lvl = 1'b0;
    prev_pulse = 1'b0;
    for (int n = 0; n < 400; ) begin
      lvl = ~lvl;
      run = $urandom_range(1, 9);
      for (int i = 0; i < run; i++) begin
        step(lvl);
        n++;
        n_checks++;
        if ({key_level, press_pulse, release_pulse} !== {m_level, m_press, m_rel}) begin
          n_fail++;
          $display("FAIL random_seq cycle %0d: got %b exp %b", n, {key_level, press_pulse, release_pulse}, {m_level, m_press, m_rel});
        end
        n_checks++;
        if ((press_pulse && release_pulse) || (prev_pulse && (press_pulse || release_pulse))) begin
          n_fail++;
          $display("FAIL pulse_spacing cycle %0d: got p=%b r=%b prev=%b exp isolated pulses", n, press_pulse, release_pulse, prev_pulse);
        end
        prev_pulse = press_pulse | release_pulse;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_press_release();
    test_release_glitch();
    test_bounce();
    test_async_reset();
    test_counter();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
